fifo_drain_arbiter: RTL
=======================

Name: fifo_drain_arbiter

Overview:
- Round-robin scheduler that shares one output byte stream between N_SRC mini FWFT FIFOs, e.g. per-chip hit queues in the readout path.
- Each FIFO is drained in bounded bursts through its first-word-fall-through read strobe.
- Every word is tagged with its source index and presented on a valid/ready output register that feeds the packetizer or serializer.

Parameters:
- N_SRC, 4, number of source FIFOs (2..16, need not be a power of 2)
- DWIDTH, 8, data word width
- MAX_BURST, 4, maximum words popped per grant (1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- resn  in  1  asynchronous active-low reset
- enable  in  1  arbitration enable
- src_empty  in  N_SRC  per-source FIFO empty flag
- src_data  in  N_SRC*DWIDTH  per-source FWFT head word; source i occupies bits [i*DWIDTH +: DWIDTH]
- src_read  out  N_SRC  per-source pop strobe, combinational, at most one bit high
- m_data  out  DWIDTH  output word (registered)
- m_src_id  out  clog2(N_SRC)  source index of m_data, clog2(N_SRC) >= 1 (registered)
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- busy  out  1  high when state is BURST or m_valid is high
- words_out  out  16  saturating count of accepted output words

Behaviour:
- Reset (resn low, asynchronous): state=IDLE, rr_ptr=0, gnt=0, burst_cnt=0, m_valid=0, m_data=0, m_src_id=0, words_out=0, src_read=0.
- FSM states: IDLE, BURST.
- IDLE: if enable=1 and any src_empty bit is 0:
  - Select the first non-empty source scanning rr_ptr, rr_ptr+1, ... modulo N_SRC.
  - Register it in gnt, clear burst_cnt, go to BURST next cycle.
  - src_read is always 0 in IDLE.
- pop = (state==BURST) & enable & !src_empty[gnt] & (burst_cnt<MAX_BURST) & (!m_valid | m_ready).
- src_read[gnt] = pop; all other src_read bits are 0.
- On pop:
  - m_data <= src_data[gnt], m_src_id <= gnt, m_valid <= 1, burst_cnt++.
  - Stay in BURST; back-to-back pops give 1 word/cycle while m_ready=1.
- BURST exit: in any BURST cycle without pop where src_empty[gnt]=1, burst_cnt==MAX_BURST, or enable=0:
  - Go to IDLE and set rr_ptr <= (gnt+1) mod N_SRC.
  - A word still held in the output register stays valid.
- Output register:
  - If m_valid & m_ready and no pop in the same cycle, m_valid <= 0.
  - While m_valid=1 and m_ready=0, m_data and m_src_id hold stable.
- Latency: source goes non-empty in IDLE at edge t -> gnt registered at t+1 -> src_read high during cycle t+1 -> m_valid at t+2. Minimum 1 dead cycle between bursts (the IDLE cycle).
- Fairness: a source holding data is granted within N_SRC-1 other bursts, each at most MAX_BURST words.
- Empty/occupancy: the arbiter never pops a source whose src_empty is high. It does not track FIFO occupancy and never reads almost flags.
- enable falling mid-burst: no further pops; the pending output word completes normally; the FSM returns to IDLE.
- words_out increments on every m_valid & m_ready cycle and holds at 16'hFFFF.
- Reset asserted mid-burst: everything returns to reset values immediately. Any in-flight output word is discarded; it was already popped from its source and is lost by design.

Test Plan:
- Single source: source 2 holds 0x11,0x22,0x33, m_ready=1 -> three output words in consecutive cycles, first at 2 cycles after non-empty, m_src_id=2; then IDLE and rr_ptr=3; words_out=3.
- Fairness: sources 0 and 1 each hold 6 words, MAX_BURST=4 -> order is src0×4, src1×4, src0×2, src1×2, with one idle cycle between bursts.
- Backpressure: m_ready held low for 5 cycles after the first word -> m_data/m_src_id stable, src_read low throughout, no word lost or duplicated; streaming resumes 1 word/cycle when m_ready returns high.
- Enable drop: deassert enable after the 2nd pop of a 4-word burst -> exactly 2 words out, FSM returns to IDLE; re-asserting enable resumes at rr_ptr=gnt+1.
- Wrap-around: N_SRC=3, only source 2 then source 0 non-empty -> grant order 2 then 0; rr_ptr wraps to 0 after the source-2 burst.
- Reset mid-burst: assert resn low between edges -> m_valid, src_read and busy drop immediately; after release, words_out=0 and the first grant goes to the lowest-indexed non-empty source.

Source files
------------

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Round-robin drain scheduler for N_SRC first-word-fall-through FIFOs.
//   Grants one source at a time and pops up to MAX_BURST words from it.
//   Each word is tagged with its source index and placed in a registered
//   valid/ready output stage.
//
// Ports
//   clk, resn            rising-edge clock, asynchronous active-low reset
//   enable               arbitration enable; when low, no new grants or pops
//   src_empty[N_SRC]     per-source FIFO empty flags
//   src_data             per-source head words, source i at [i*DWIDTH +: DWIDTH]
//   src_read[N_SRC]      per-source pop strobe (combinational, one-hot or zero)
//   m_data, m_src_id     registered output word and its source index
//   m_valid, m_ready     output handshake
//   busy                 high while in BURST or while an output word is held
//   words_out            saturating count of accepted output words
//
// Handshake: a word transfers on a rising edge where m_valid and m_ready are
// both high. Once m_valid is high it stays high, and m_data/m_src_id stay
// stable, until that transfer happens.
module fifo_drain_arbiter #(
    parameter int  N_SRC     = 4,
    parameter int  DWIDTH    = 8,
    parameter int  MAX_BURST = 4,
    localparam int ID_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    resn,
    input  logic                    enable,
    input  logic [N_SRC-1:0]        src_empty,
    input  logic [N_SRC*DWIDTH-1:0] src_data,
    output logic [N_SRC-1:0]        src_read,
    output logic [DWIDTH-1:0]       m_data,
    output logic [ID_W-1:0]         m_src_id,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy,
    output logic [15:0]             words_out
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int SUM_W = ID_W + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              m_valid_q, m_valid_d;
    logic [DWIDTH-1:0] m_data_q, m_data_d;
    logic [ID_W-1:0]   m_src_id_q, m_src_id_d;
    logic [15:0]       words_out_q, words_out_d;

    logic [DWIDTH-1:0]  src_word [N_SRC];
    logic [2*N_SRC-1:0] req2;
    logic [2*N_SRC-1:0] rot;
    logic [ID_W-1:0]    offset;
    logic [SUM_W-1:0]   sel_sum;
    logic [SUM_W-1:0]   succ_sum;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    gnt_succ;
    logic               pop;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_word[i] = src_data[i*DWIDTH +: DWIDTH];
        end
    end

    // Round-robin pick: rotate the doubled request vector so rr_ptr lands at
    // bit 0, take the lowest set bit, then map the offset back modulo N_SRC.
    always_comb begin
        req2   = {~src_empty, ~src_empty};
        rot    = req2 >> rr_ptr_q;
        offset = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot[i]) offset = ID_W'(i);
        end
        sel_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
        if (sel_sum >= SUM_W'(N_SRC)) sel_sum = sel_sum - SUM_W'(N_SRC);
        sel = sel_sum[ID_W-1:0];

        succ_sum = {1'b0, gnt_q} + SUM_W'(1);
        if (succ_sum >= SUM_W'(N_SRC)) succ_sum = succ_sum - SUM_W'(N_SRC);
        gnt_succ = succ_sum[ID_W-1:0];
    end

    assign pop = (state_q == ST_BURST) && enable && !src_empty[gnt_q] &&
                 (burst_cnt_q < CNT_W'(MAX_BURST)) && (!m_valid_q || m_ready);

    always_comb begin
        src_read        = '0;
        src_read[gnt_q] = pop;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        burst_cnt_d = burst_cnt_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_src_id_d  = m_src_id_q;
        words_out_d = words_out_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && (|(~src_empty))) begin
                    gnt_d       = sel;
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            default: begin
                if (pop) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else if (src_empty[gnt_q] || !enable ||
                             (burst_cnt_q == CNT_W'(MAX_BURST))) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = gnt_succ;
                end
                // Otherwise the burst is only stalled by output backpressure.
            end
        endcase

        if (pop) begin
            m_data_d   = src_word[gnt_q];
            m_src_id_d = gnt_q;
            m_valid_d  = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (m_valid_q && m_ready && (words_out_q != 16'hFFFF)) begin
            words_out_d = words_out_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            burst_cnt_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_src_id_q  <= '0;
            words_out_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            burst_cnt_q <= burst_cnt_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_src_id_q  <= m_src_id_d;
            words_out_q <= words_out_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_src_id  = m_src_id_q;
    assign m_valid   = m_valid_q;
    assign words_out = words_out_q;
    assign busy      = (state_q == ST_BURST) || m_valid_q;

endmodule
